seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an N-digit common-anode seven-segment display.
// A loaded hex word and its decimal points are held in a pending buffer and reach the shadow
// register only at a slot boundary, so a digit's content never changes mid-slot. Each slot
// starts with BLANK_CYCLES of all-off outputs to stop ghosting, then drives one digit.
// Leading zeros can be suppressed.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   digits_in  hex nibbles; nibble i = bits [4i+3:4i]; digit 0 is the rightmost
//   dp_in      decimal point request per digit, 1 = lit
//   load       one-cycle strobe capturing digits_in/dp_in into the pending buffer
//   lz_en      leading-zero suppression enable, used live
//   seg7       active-low segments; bit7 = DP, bits 6..0 = g..a (registered)
//   dig_sel    active-low anode select, one-cold while driving (registered)
module seg7_scan_driver #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [7:0]            seg7,
  output logic [N_DIGITS-1:0]   dig_sel
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(N_DIGITS - 1);

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  // Hex nibble to active-low segments g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [N_DIGITS-1:0][3:0]    pend_dig_q, pend_dig_d;
  logic [N_DIGITS-1:0]         pend_dp_q, pend_dp_d;
  logic                        pend_vld_q, pend_vld_d;
  logic [N_DIGITS-1:0][3:0]    sh_dig_q, sh_dig_d;
  logic [N_DIGITS-1:0]         sh_dp_q, sh_dp_d;
  logic [7:0]                  seg_q, seg_d;
  logic [N_DIGITS-1:0]         sel_q, sel_d;
  state_e                      state;
  logic                        boundary;
  logic                        upper_zero;
  logic                        suppress;

  always_comb begin
    boundary = (cnt_q == CntMax);
    cnt_d    = boundary ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (boundary) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end

    // Shadow only updates at a boundary; a load on that same cycle stays pending one more slot.
    sh_dig_d   = sh_dig_q;
    sh_dp_d    = sh_dp_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (boundary && pend_vld_q) begin
      sh_dig_d   = pend_dig_q;
      sh_dp_d    = pend_dp_q;
      pend_vld_d = 1'b0;
    end
    if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end

    state = (int'(cnt_q) < int'(BLANK_CYCLES)) ? StBlank : StDrive;

    // The current digit is a leading zero if it and every digit to its left are zero.
    upper_zero = 1'b1;
    for (int j = 0; j < int'(N_DIGITS); j++) begin
      if ((j >= int'(idx_q)) && (sh_dig_q[j] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    suppress = lz_en && (idx_q != '0) && upper_zero;

    seg_d = 8'hFF;
    sel_d = '1;
    if (state == StDrive) begin
      sel_d = ~(N_DIGITS'(1) << idx_q);
      seg_d = {~sh_dp_q[idx_q], suppress ? 7'h7F : hex_to_seg(sh_dig_q[idx_q])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      sh_dig_q   <= '0;
      sh_dp_q    <= '0;
      seg_q      <= 8'hFF;
      sel_q      <= '1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      sh_dig_q   <= sh_dig_d;
      sh_dp_q    <= sh_dp_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end

  assign seg7    = seg_q;
  assign dig_sel = sel_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: two instances (slow scan with blanking, and a
// one-cycle slot with no blanking) share stimulus; a time-based reference model pushes the
// expected pin values per clock and a monitor pops and compares after each edge.
module tb_seg7_scan_driver;

  localparam int N   = 4;
  localparam int CD0 = 8;
  localparam int BC0 = 2;
  localparam int CD1 = 1;
  localparam int BC1 = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [7:0]  seg0, seg1;
  logic [3:0]  sel0, sel1;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(N), .CLK_DIV(CD0), .BLANK_CYCLES(BC0)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits_in(digits_in),
    .dp_in    (dp_in),
    .load     (load),
    .lz_en    (lz_en),
    .seg7     (seg0),
    .dig_sel  (sel0)
  );

  seg7_scan_driver #(.N_DIGITS(N), .CLK_DIV(CD1), .BLANK_CYCLES(BC1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits_in(digits_in),
    .dp_in    (dp_in),
    .load     (load),
    .lz_en    (lz_en),
    .seg7     (seg1),
    .dig_sel  (sel1)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] sel;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t last0;
  int   total = 0;
  int   bad = 0;

  // Full display codes with DP off, indexed by hex value.
  logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state: cycles since reset release, pending buffer, shown word.
  int          m_cyc [2];
  logic [15:0] m_pend [2];
  logic [3:0]  m_pdp [2];
  logic        m_pv [2];
  logic [15:0] m_sh [2];
  logic [3:0]  m_sdp [2];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cyc[k]  = 0;
      m_pend[k] = '0;
      m_pdp[k]  = '0;
      m_pv[k]   = 1'b0;
      m_sh[k]   = '0;
      m_sdp[k]  = '0;
    end
  endtask

  // Expected pins after the coming clock edge, given the inputs presented for it.
  task automatic model_step(input int k, input int cd, input int bc, output exp_t e);
    int          pos;
    int          dig;
    logic [15:0] sh;
    logic [7:0]  code;
    logic        supp;
    pos = m_cyc[k] % cd;
    dig = (m_cyc[k] / cd) % N;
    if (pos < bc) begin
      e.seg = 8'hFF;
      e.sel = 4'hF;
    end else begin
      sh    = m_sh[k] >> (4 * dig);
      supp  = lz_en && (dig > 0) && (sh == 16'h0);
      code  = tbl[sh[3:0]];
      e.sel = 4'hF ^ (4'b0001 << dig);
      e.seg = {~m_sdp[k][dig], supp ? 7'h7F : code[6:0]};
    end
    if ((pos == cd - 1) && m_pv[k]) begin
      m_sh[k]  = m_pend[k];
      m_sdp[k] = m_pdp[k];
      m_pv[k]  = 1'b0;
    end
    if (load) begin
      m_pend[k] = digits_in;
      m_pdp[k]  = dp_in;
      m_pv[k]   = 1'b1;
    end
    m_cyc[k]++;
  endtask

  // Called at a falling edge: present inputs, predict the next edge, advance one cycle.
  task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] p,
                       input logic lz);
    exp_t e;
    load      = ld;
    digits_in = d;
    dp_in     = p;
    lz_en     = lz;
    model_step(0, CD0, BC0, e);
    q0.push_back(e);
    last0 = e;
    model_step(1, CD1, BC1, e);
    q1.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic lz);
    for (int i = 0; i < n; i++) cycle(1'b0, digits_in, dp_in, lz);
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_seg0"}, seg0, 8'hFF);
    chk({tag, "_sel0"}, {4'h0, sel0}, 8'h0F);
    chk({tag, "_seg1"}, seg1, 8'hFF);
    chk({tag, "_sel1"}, {4'h0, sel1}, 8'h0F);
  endtask

  // Holds reset through one rising edge, then releases on a falling edge.
  task automatic release_after();
    @(negedge clk);
    rst_checks("in_rst");
    model_reset();
    load  = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b0;
    #1;
    rst_checks("rst");
    release_after();
  endtask

  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("sb0_seg", seg0, e.seg);
        chk("sb0_sel", {4'h0, sel0}, {4'h0, e.sel});
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("sb1_seg", seg1, e.seg);
        chk("sb1_sel", {4'h0, sel1}, {4'h0, e.sel});
      end
    end
  end

  initial begin : watchdog
    #400000;
    bad++;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stim
    logic [15:0] masks [5];
    logic [15:0] d;
    logic        lz;
    int          n;
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

    do_reset();
    idle(40, 1'b0);

    // Mixed digits with one decimal point.
    cycle(1'b1, 16'h1A3F, 4'b0100, 1'b0);
    idle(40, 1'b0);

    // Leading-zero suppression on, then off.
    cycle(1'b1, 16'h0007, 4'b0000, 1'b1);
    idle(40, 1'b1);
    idle(40, 1'b0);

    // Two loads in one slot: the second must win.
    n = 0;
    while ((m_cyc[0] % CD0 != 3) && (n < 20)) begin
      cycle(1'b0, digits_in, dp_in, 1'b0);
      n++;
    end
    cycle(1'b1, 16'h1111, 4'b0000, 1'b0);
    cycle(1'b1, 16'h2222, 4'b0000, 1'b0);
    idle(40, 1'b0);

    // Load exactly on a boundary cycle.
    n = 0;
    while ((m_cyc[0] % CD0 != CD0 - 1) && (n < 20)) begin
      cycle(1'b0, digits_in, dp_in, 1'b0);
      n++;
    end
    cycle(1'b1, 16'h3C5E, 4'b1001, 1'b0);
    idle(24, 1'b0);

    // Random phase.
    lz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) lz = ~lz;
      if ($urandom_range(0, 9) == 0) begin
        d = 16'($urandom) & masks[$urandom_range(0, 4)];
        cycle(1'b1, d, 4'($urandom), lz);
      end else begin
        cycle(1'b0, digits_in, dp_in, lz);
      end
    end

    // Asynchronous reset while instance 0 drives digit 2.
    n = 0;
    while ((last0.sel != 4'hB) && (n < 200)) begin
      cycle(1'b0, digits_in, dp_in, lz);
      n++;
    end
    chk("pre_rst_sel0", {4'h0, sel0}, 8'h0B);
    #2;
    rst_n = 1'b0;
    #1;
    rst_checks("async_rst");
    release_after();
    idle(40, 1'b0);

    // Let the monitor consume the final entry.
    @(posedge clk);
    #2;
    total++;
    if ((q0.size() != 0) || (q1.size() != 0)) begin
      bad++;
      $display("FAIL drain got=%0d/%0d want=0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
